// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, ALUOp encodings and the decoded control word
package ctrl_pkg;
    localparam int CTRL_ALUOP_W = 2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BGEZ  = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [CTRL_ALUOP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_BR  = 2'b01;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_RT  = 2'b10;
    localparam logic [CTRL_ALUOP_W-1:0] ALU_IMM = 2'b11;

    typedef struct packed {
        logic [CTRL_ALUOP_W-1:0] aluop;
        logic                    regdst;
        logic                    alusrc;
        logic                    branch;
        logic                    jump;
        logic                    memread;
        logic                    memwrite;
        logic                    regwrite;
        logic                    memtoreg;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational ID-stage instruction to control-word decoder
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_word_t  o_ctrl
);
    logic [5:0] w_op;

    assign w_op = i_instr[31:26];

    // An all-zero word is a NOP, not an R-type sll $0,$0,0
    always_comb begin
        o_ctrl = CTRL_NOP;
        if (i_instr != '0) begin
            case (w_op)
                OP_RTYPE: begin
                    o_ctrl.aluop    = ALU_RT;
                    o_ctrl.regdst   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                end
                OP_LW: begin
                    o_ctrl.aluop    = ALU_ADD;
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.memread  = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.memtoreg = 1'b1;
                end
                OP_SW: begin
                    o_ctrl.aluop    = ALU_ADD;
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.memwrite = 1'b1;
                end
                OP_ADDI, OP_ADDIU: begin
                    o_ctrl.aluop    = ALU_ADD;
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                end
                OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                    o_ctrl.aluop    = ALU_IMM;
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                end
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ: begin
                    o_ctrl.aluop  = ALU_BR;
                    o_ctrl.branch = 1'b1;
                end
                OP_J: o_ctrl.jump = 1'b1;
                default: o_ctrl = CTRL_NOP;
            endcase
        end
    end
endmodule

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: decodes ID, carries control through ID/EX, EX/MEM, MEM/WB,
// and generates load-use stall plus branch/jump flush controls.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = CTRL_ALUOP_W,
    parameter bit JUMP_FLUSH = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr_id,
    input  logic                  branch_taken_ex,
    output logic                  stall_o,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  jump_id_o,
    output logic [ALUOP_W-1:0]    ex_aluop_o,
    output logic                  ex_alusrc_o,
    output logic                  ex_branch_o,
    output logic [REG_ADDR_W-1:0] ex_rs_o,
    output logic [REG_ADDR_W-1:0] ex_rt_o,
    output logic [REG_ADDR_W-1:0] ex_dst_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  mem_regwrite_o,
    output logic [REG_ADDR_W-1:0] mem_dst_o,
    output logic                  wb_regwrite_o,
    output logic                  wb_memtoreg_o,
    output logic [REG_ADDR_W-1:0] wb_dst_o
);
    ctrl_word_t            w_dec;
    logic [REG_ADDR_W-1:0] w_rs, w_rt, w_rd, w_dst;
    logic                  w_raw_hz, w_bubble;

    logic [ALUOP_W-1:0]    r_ex_aluop;
    logic                  r_ex_alusrc, r_ex_branch, r_ex_memread, r_ex_memwrite;
    logic                  r_ex_regwrite, r_ex_memtoreg;
    logic [REG_ADDR_W-1:0] r_ex_rs, r_ex_rt, r_ex_dst;
    logic                  r_mem_read, r_mem_write, r_mem_regwrite, r_mem_memtoreg;
    logic [REG_ADDR_W-1:0] r_mem_dst;
    logic                  r_wb_regwrite, r_wb_memtoreg;
    logic [REG_ADDR_W-1:0] r_wb_dst;

    ctrl_decode u_dec (
        .i_instr (instr_id),
        .o_ctrl  (w_dec)
    );

    assign w_rs  = REG_ADDR_W'(instr_id[25:21]);
    assign w_rt  = REG_ADDR_W'(instr_id[20:16]);
    assign w_rd  = REG_ADDR_W'(instr_id[15:11]);
    assign w_dst = w_dec.regwrite ? (w_dec.regdst ? w_rd : w_rt) : '0;

    // A taken branch squashes the dependent instruction, so it overrides the stall
    assign w_raw_hz     = r_ex_memread && (r_ex_dst != '0) && ((r_ex_dst == w_rs) || (r_ex_dst == w_rt));
    assign stall_o      = w_raw_hz && !branch_taken_ex;
    assign pc_write_o   = !stall_o;
    assign ifid_write_o = !stall_o;
    assign jump_id_o    = w_dec.jump;
    assign ifid_flush_o = branch_taken_ex || (JUMP_FLUSH && jump_id_o && !stall_o);
    assign w_bubble     = branch_taken_ex || stall_o;

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_ex_aluop    <= '0;
            r_ex_alusrc   <= 1'b0;
            r_ex_branch   <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
            r_ex_dst      <= '0;
        end else begin
            r_ex_aluop    <= ALUOP_W'(w_dec.aluop);
            r_ex_alusrc   <= w_dec.alusrc;
            r_ex_branch   <= w_dec.branch;
            r_ex_memread  <= w_dec.memread;
            r_ex_memwrite <= w_dec.memwrite;
            r_ex_regwrite <= w_dec.regwrite;
            r_ex_memtoreg <= w_dec.memtoreg;
            r_ex_rs       <= w_rs;
            r_ex_rt       <= w_rt;
            r_ex_dst      <= w_dst;
        end
        if (rst) begin
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_dst      <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_dst       <= '0;
        end else begin
            r_mem_read     <= r_ex_memread;
            r_mem_write    <= r_ex_memwrite;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memtoreg <= r_ex_memtoreg;
            r_mem_dst      <= r_ex_dst;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_dst       <= r_mem_dst;
        end
    end

    assign ex_aluop_o     = r_ex_aluop;
    assign ex_alusrc_o    = r_ex_alusrc;
    assign ex_branch_o    = r_ex_branch;
    assign ex_rs_o        = r_ex_rs;
    assign ex_rt_o        = r_ex_rt;
    assign ex_dst_o       = r_ex_dst;
    assign mem_read_o     = r_mem_read;
    assign mem_write_o    = r_mem_write;
    assign mem_regwrite_o = r_mem_regwrite;
    assign mem_dst_o      = r_mem_dst;
    assign wb_regwrite_o  = r_wb_regwrite;
    assign wb_memtoreg_o  = r_wb_memtoreg;
    assign wb_dst_o       = r_wb_dst;
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb_ctrl_pipe_unit: directed test of decode, stage pipelining, stall and flush
module tb_ctrl_pipe_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_id;
    logic        branch_taken_ex;

    logic       stall, pcw, ifw, flush, jmp;
    logic [1:0] ex_aluop;
    logic       ex_alusrc, ex_branch;
    logic [4:0] ex_rs, ex_rt, ex_dst;
    logic       mem_rd, mem_wr, mem_rw;
    logic [4:0] mem_dst;
    logic       wb_rw, wb_m2r;
    logic [4:0] wb_dst;

    logic       n_stall, n_pcw, n_ifw, n_flush, n_jmp;
    logic [1:0] n_ex_aluop;
    logic       n_ex_alusrc, n_ex_branch;
    logic [4:0] n_ex_rs, n_ex_rt, n_ex_dst;
    logic       n_mem_rd, n_mem_wr, n_mem_rw;
    logic [4:0] n_mem_dst;
    logic       n_wb_rw, n_wb_m2r;
    logic [4:0] n_wb_dst;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe_unit #(.JUMP_FLUSH(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .branch_taken_ex(branch_taken_ex),
        .stall_o(stall), .pc_write_o(pcw), .ifid_write_o(ifw), .ifid_flush_o(flush),
        .jump_id_o(jmp), .ex_aluop_o(ex_aluop), .ex_alusrc_o(ex_alusrc),
        .ex_branch_o(ex_branch), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_dst_o(ex_dst),
        .mem_read_o(mem_rd), .mem_write_o(mem_wr), .mem_regwrite_o(mem_rw),
        .mem_dst_o(mem_dst), .wb_regwrite_o(wb_rw), .wb_memtoreg_o(wb_m2r),
        .wb_dst_o(wb_dst)
    );

    ctrl_pipe_unit #(.JUMP_FLUSH(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .instr_id(instr_id), .branch_taken_ex(branch_taken_ex),
        .stall_o(n_stall), .pc_write_o(n_pcw), .ifid_write_o(n_ifw), .ifid_flush_o(n_flush),
        .jump_id_o(n_jmp), .ex_aluop_o(n_ex_aluop), .ex_alusrc_o(n_ex_alusrc),
        .ex_branch_o(n_ex_branch), .ex_rs_o(n_ex_rs), .ex_rt_o(n_ex_rt), .ex_dst_o(n_ex_dst),
        .mem_read_o(n_mem_rd), .mem_write_o(n_mem_wr), .mem_regwrite_o(n_mem_rw),
        .mem_dst_o(n_mem_dst), .wb_regwrite_o(n_wb_rw), .wb_memtoreg_o(n_wb_m2r),
        .wb_dst_o(n_wb_dst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        instr_id = 32'h8C010004;
        branch_taken_ex = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_aluop", 32'(ex_aluop), 0);
        chk("rst_ex_ctl", {ex_alusrc, ex_branch}, 0);
        chk("rst_ex_tags", {ex_rs, ex_rt, ex_dst}, 0);
        chk("rst_mem", {mem_rd, mem_wr, mem_rw, mem_dst}, 0);
        chk("rst_wb", {wb_rw, wb_m2r, wb_dst}, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_pcw", {pcw, ifw}, 32'b11);

        // add $3,$1,$2 through all stages
        rst = 1'b0;
        instr_id = 32'h00221820;
        #1;
        chk("add_jump_id", 32'(jmp), 0);
        chk("add_flush", 32'(flush), 0);
        tick();
        instr_id = 32'h0;
        chk("add_ex_aluop", 32'(ex_aluop), 32'h2);
        chk("add_ex_dst", 32'(ex_dst), 3);
        chk("add_ex_rsrt", {ex_rs, ex_rt}, {5'd1, 5'd2});
        chk("add_ex_alusrc", 32'(ex_alusrc), 0);
        tick();
        chk("add_mem", {mem_rw, mem_dst}, {1'b1, 5'd3});
        chk("nop_ex_aluop", 32'(ex_aluop), 0);
        tick();
        chk("add_wb", {wb_rw, wb_m2r, wb_dst}, {1'b1, 1'b0, 5'd3});

        // lw $1 then dependent add: one-cycle stall and bubble
        instr_id = 32'h8C010004;
        #1;
        chk("lw_no_stall_yet", 32'(stall), 0);
        tick();
        chk("lw_ex", {ex_alusrc, ex_aluop, ex_dst}, {1'b1, 2'b00, 5'd1});
        instr_id = 32'h00221820;
        #1;
        chk("lu_stall", 32'(stall), 1);
        chk("lu_pcw", {pcw, ifw}, 0);
        chk("lu_flush", 32'(flush), 0);
        tick();
        chk("lu_bubble", {ex_aluop, ex_alusrc, ex_rs, ex_rt, ex_dst}, 0);
        chk("lu_mem_lw", {mem_rd, mem_rw, mem_dst}, {1'b1, 1'b1, 5'd1});
        chk("lu_stall_drop", 32'(stall), 0);
        chk("lu_pcw_back", {pcw, ifw}, 32'b11);
        tick();
        chk("lu_add_ex", {ex_aluop, ex_dst}, {2'b10, 5'd3});
        chk("lu_wb_lw", {wb_rw, wb_m2r, wb_dst}, {1'b1, 1'b1, 5'd1});

        // stall and taken branch together: branch wins
        instr_id = 32'h8C010004;
        tick();
        instr_id = 32'h00221820;
        branch_taken_ex = 1'b1;
        #1;
        chk("br_no_stall", 32'(stall), 0);
        chk("br_flush", 32'(flush), 1);
        chk("br_pcw", 32'(pcw), 1);
        tick();
        branch_taken_ex = 1'b0;
        chk("br_bubble", {ex_aluop, ex_alusrc, ex_branch, ex_rs, ex_rt, ex_dst}, 0);
        chk("br_mem_lw", 32'(mem_rd), 1);

        // jump with and without flush
        instr_id = 32'h08000040;
        #1;
        chk("j_jump_id", {jmp, n_jmp}, 32'b11);
        chk("j_flush", 32'(flush), 1);
        chk("j_noflush_mode", 32'(n_flush), 0);
        tick();
        chk("j_ex_zero", {ex_aluop, ex_alusrc, ex_branch, ex_dst}, 0);

        // jump stalled behind a load: flush deferred until the stall clears
        instr_id = 32'h8C010004;
        tick();
        instr_id = 32'h08010000;
        #1;
        chk("js_stall", 32'(stall), 1);
        chk("js_flush_held", 32'(flush), 0);
        tick();
        chk("js_stall_clear", 32'(stall), 0);
        chk("js_flush", 32'(flush), 1);

        // lw to $0 never stalls
        instr_id = 32'h8C000000;
        tick();
        chk("lw0_dst", 32'(ex_dst), 0);
        instr_id = 32'h00001820;
        #1;
        chk("lw0_no_stall", 32'(stall), 0);
        tick();
        chk("lw0_add_ex", 32'(ex_dst), 3);

        // NOP drains everything to zero
        instr_id = 32'h0;
        repeat (3) tick();
        chk("nop_all", {ex_aluop, ex_alusrc, ex_branch, ex_dst, mem_rd, mem_wr, mem_rw,
                        mem_dst, wb_rw, wb_m2r, wb_dst}, 0);

        // other decode classes
        instr_id = 32'h10220003;
        tick();
        chk("beq_ex", {ex_branch, ex_aluop, ex_alusrc, ex_dst}, {1'b1, 2'b01, 1'b0, 5'd0});
        instr_id = 32'hAC220008;
        tick();
        chk("sw_ex", {ex_alusrc, ex_aluop, ex_dst}, {1'b1, 2'b00, 5'd0});
        instr_id = 32'h34230005;
        tick();
        chk("ori_ex", {ex_aluop, ex_alusrc, ex_dst}, {2'b11, 1'b1, 5'd3});
        chk("sw_mem", {mem_wr, mem_rw, mem_dst}, {1'b1, 1'b0, 5'd0});
        instr_id = 32'h0C220000;
        tick();
        chk("bgez_ex", {ex_branch, ex_aluop}, {1'b1, 2'b01});
        instr_id = 32'hFC220000;
        tick();
        chk("unk_ex", {ex_aluop, ex_alusrc, ex_branch, ex_dst}, 0);

        // reset asserted mid-stall
        instr_id = 32'h8C010004;
        tick();
        instr_id = 32'h00221820;
        #1;
        chk("rs_stall", 32'(stall), 1);
        rst = 1'b1;
        tick();
        chk("rs_stall_drop", 32'(stall), 0);
        chk("rs_empty", {ex_aluop, ex_dst, mem_rd, mem_rw, mem_dst}, 0);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Next-generation control unit for the 5-stage MIPS pipeline. It decodes the ID-stage instruction into a control word, then carries that word and the destination register through the ID/EX, EX/MEM and MEM/WB stage registers. It also detects load-use hazards, generating stall and bubble controls, and applies branch/jump flushes. It replaces the purely combinational decoder plus the scattered control pipeline registers.

Parameters:
REG_ADDR_W, 5, register-index width (rs/rt/rd fields, destination tags)
ALUOP_W, 2, ALUOp width passed to ALU control
JUMP_FLUSH, 1, 1 = a jump decoded in ID flushes IF/ID; 0 = no flush (delay-slot mode)

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
instr_id  in  32  IF/ID instruction register contents
branch_taken_ex  in  1  branch resolved taken in EX this cycle
stall_o  out  1  load-use stall (combinational)
pc_write_o  out  1  PC update enable = !stall_o
ifid_write_o  out  1  IF/ID load enable = !stall_o
ifid_flush_o  out  1  zero IF/ID next edge (combinational)
jump_id_o  out  1  jump decoded in ID (combinational, 0 for NOP)
ex_aluop_o  out  ALUOP_W  registered ID/EX ALUOp
ex_alusrc_o  out  1  ID/EX ALUSrc
ex_branch_o  out  1  ID/EX Branch
ex_rs_o, ex_rt_o  out  REG_ADDR_W  ID/EX source tags, for the forwarding unit
ex_dst_o  out  REG_ADDR_W  ID/EX destination (rd if RegDest else rt)
mem_read_o, mem_write_o  out  1  EX/MEM memory controls
mem_regwrite_o  out  1  EX/MEM RegWrite
mem_dst_o  out  REG_ADDR_W  EX/MEM destination
wb_regwrite_o, wb_memtoreg_o  out  1  MEM/WB writeback controls
wb_dst_o  out  REG_ADDR_W  MEM/WB destination

Behaviour:
- Decode (combinational, ID): opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11].
  - R-type: ALUOp 10, RegDest, RegWrite.
  - lw: ALUOp 00, ALUSrc, MemRead, RegWrite, MemToReg.
  - sw: ALUOp 00, ALUSrc, MemWrite.
  - addi/addiu: ALUOp 00, ALUSrc, RegWrite.
  - slti/sltiu/andi/ori/xori: ALUOp 11, ALUSrc, RegWrite.
  - beq/bne/blez/bgtz/bltz(000001)/bgez(000011): ALUOp 01, Branch.
  - j: Jump only.
  - instr == 0 or unknown opcode: all-zero control word.
- Destination tag is forced to 0 whenever RegWrite = 0.
- Hazard: raw_hz = ex_mem_read_q && ex_dst_o != 0 && (ex_dst_o == rs || ex_dst_o == rt). stall_o = raw_hz && !branch_taken_ex.
- ifid_flush_o = branch_taken_ex || (JUMP_FLUSH && jump_id_o && !stall_o).
- ID/EX update priority:
  - rst → all zero.
  - branch_taken_ex or stall_o → bubble: all controls and tags zero.
  - Otherwise load the decoded word.
- EX/MEM and MEM/WB always advance (no stall or flush beyond ID/EX).
  - On a branch flush, the instruction in EX (the branch itself) still advances.
  - rst zeroes both stages.
- Latency: decode → ex_* outputs 1 cycle, mem_* 2 cycles, wb_* 3 cycles.
- Reset: every registered output is 0. Combinational outputs follow: stall_o = 0, pc_write_o = ifid_write_o = 1.
- Simultaneous stall and branch_taken_ex: the branch wins. No stall; IF/ID is flushed and ID/EX is bubbled.
- Stall with jump in ID: no flush that cycle; the jump is re-presented and flushes once the stall clears.
- A back-to-back second stall is impossible: the bubble has MemRead = 0.
- Reset asserted mid-stall: the pipeline empties next edge and the stall drops.

Decomposition:
- Shared package ctrl_pkg holds:
  - Opcode localparams.
  - ALUOp encodings (ALU_ADD = 00, ALU_BR = 01, ALU_RT = 10, ALU_IMM = 11).
  - A packed control-word struct ctrl_word_t {aluop, regdst, alusrc, branch, jump, memread, memwrite, regwrite, memtoreg}.
  - Constant CTRL_NOP = '0.
- One sub-module ctrl_decode: the combinational instr → ctrl_word_t decoder, including the NOP and default cases.
- Stage registers and hazard logic stay in the top.

Test Plan:
- rst high for 2 cycles with instr_id = 8C010004 → all registered outputs 0, stall_o = 0, pc_write_o = 1.
- add $3,$1,$2 (00221820) → ex_aluop_o = 10, ex_dst_o = 3; next cycle mem_regwrite_o = 1, mem_dst_o = 3; next cycle wb_regwrite_o = 1, wb_memtoreg_o = 0, wb_dst_o = 3.
- lw $1,4($0) then add $3,$1,$2 → stall_o = 1 for exactly one cycle, pc_write_o = ifid_write_o = 0, bubble in ID/EX; add enters EX the following cycle with ex_dst_o = 3.
- lw $1 in EX, add using $1 in ID, branch_taken_ex = 1 same cycle → stall_o = 0, ifid_flush_o = 1, next ex_* all zero.
- j 0x100 (08000040) in ID, JUMP_FLUSH = 1 → jump_id_o = 1, ifid_flush_o = 1, ID/EX holds the zero control word; JUMP_FLUSH = 0 → ifid_flush_o = 0.
- lw $0,0($0) then add using $0 → no stall (dest tag 0); instr 00000000 → all controls 0 at each stage.
